adder_tree_pipe: RTL and testbench

Parametrised, fully pipelined unsigned adder tree that reduces N_IN packed operands to a single sum, one register stage per tree level. It optionally accumulates tree sums across multi-beat frames. It sits downstream of the per-pair adder stages in the competition datapath and replaces chains of hand-instantiated fixed-width stages with one configurable block. Flow control is valid/ready, with a whole-pipeline stall on output backpressure.

---
 rtl/adder_tree_pipe.sv | 168 ++++++++++++++++
 tb/tb_adder_tree_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe
// Fully pipelined unsigned adder tree. It reduces N_IN packed operands to a
// single sum, with one register stage per tree level and an output/accumulate
// register after the last level. It can optionally accumulate tree sums over
// a multi-beat frame that ends with in_last.
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (low while output is stalled)
//   in_data    N_IN packed operands, operand i = in_data[i*IN_W +: IN_W]
//   in_last    final beat of an accumulation frame
//   acc_mode   0: one sum per beat, 1: accumulate until in_last
//   out_valid  out_sum/out_last valid
//   out_ready  downstream accepts the result
//   out_sum    result (SUM_W bits, zero-extended tree sum in mode 0)
//   out_last   in_last of the beat that produced the result
module adder_tree_pipe #(
  parameter int unsigned IN_W  = 14,
  parameter int unsigned N_IN  = 16,
  parameter int unsigned ACC_W = 4
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_IN*IN_W-1:0]                  in_data,
  input  logic                                  in_last,
  input  logic                                  acc_mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [IN_W+$clog2(N_IN)+ACC_W-1:0]    out_sum,
  output logic                                  out_last
);

  localparam int unsigned LEVELS = $clog2(N_IN);
  localparam int unsigned TREE_W = IN_W + LEVELS;
  localparam int unsigned SUM_W  = TREE_W + ACC_W;

  logic              stall;
  logic              accept;

  logic [TREE_W-1:0] tree_sum;
  logic              tree_vld;
  logic              tree_mode;
  logic              tree_last;

  logic [SUM_W-1:0]  acc_d, acc_q;
  logic [SUM_W-1:0]  out_sum_d, out_sum_q;
  logic              out_valid_d, out_valid_q;
  logic              out_last_d, out_last_q;

  // A held result that downstream has not taken freezes the whole pipeline.
  always_comb begin
    stall    = out_valid_q && !out_ready;
    in_ready = !stall;
    accept   = in_valid && in_ready;
  end

  // Level k holds N_IN>>k sums of width IN_W+k; it reads the full-width
  // results of level k-1 (or the raw operands for k = 1), so nothing truncates.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned NK = N_IN >> k;
    localparam int unsigned WK = IN_W + k;

    logic [2*NK*(WK-1)-1:0] src;
    logic [NK*WK-1:0]       sum_d, sum_q;
    logic                   vld_d, vld_q;
    logic                   mode_d, mode_q;
    logic                   last_d, last_q;

    if (k == 1) begin : g_src
      always_comb begin
        src    = in_data;
        vld_d  = accept;
        mode_d = acc_mode;
        last_d = in_last;
      end
    end else begin : g_src
      always_comb begin
        src    = g_lvl[k-1].sum_q;
        vld_d  = g_lvl[k-1].vld_q;
        mode_d = g_lvl[k-1].mode_q;
        last_d = g_lvl[k-1].last_q;
      end
    end

    always_comb begin
      sum_d = '0;
      for (int unsigned i = 0; i < NK; i++) begin
        sum_d[i*WK +: WK] = WK'(src[(2*i)*(WK-1) +: WK-1])
                          + WK'(src[(2*i+1)*(WK-1) +: WK-1]);
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        sum_q  <= '0;
        vld_q  <= 1'b0;
        mode_q <= 1'b0;
        last_q <= 1'b0;
      end else if (!stall) begin
        sum_q  <= sum_d;
        vld_q  <= vld_d;
        mode_q <= mode_d;
        last_q <= last_d;
      end
    end

    if (k == LEVELS) begin : g_root
      always_comb begin
        tree_sum  = sum_q;
        tree_vld  = vld_q;
        tree_mode = mode_q;
        tree_last = last_q;
      end
    end
  end

  // Output / accumulate stage. A mode-0 beat also clears the accumulator,
  // which is how a partial mode-1 frame gets discarded.
  always_comb begin
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (!stall) begin
      out_valid_d = 1'b0;
      if (tree_vld) begin
        if (!tree_mode) begin
          out_sum_d   = SUM_W'(tree_sum);
          out_valid_d = 1'b1;
          out_last_d  = tree_last;
          acc_d       = '0;
        end else if (!tree_last) begin
          acc_d = acc_q + SUM_W'(tree_sum);
        end else begin
          out_sum_d   = acc_q + SUM_W'(tree_sum);
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          acc_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    out_sum   = out_sum_q;
    out_valid = out_valid_q;
    out_last  = out_last_q;
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe with default parameters.
// Expected results are queued when a beat is driven and compared whenever the
// DUT completes an output handshake.
module tb_adder_tree_pipe;

  localparam int unsigned IN_W   = 14;
  localparam int unsigned N_IN   = 16;
  localparam int unsigned ACC_W  = 4;
  localparam int unsigned LEVELS = $clog2(N_IN);
  localparam int unsigned SUM_W  = IN_W + LEVELS + ACC_W;
  localparam int unsigned DW     = N_IN * IN_W;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             in_last = 1'b0;
  logic             acc_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [SUM_W-1:0] out_sum;
  logic             out_last;

  adder_tree_pipe #(
    .IN_W (IN_W),
    .N_IN (N_IN),
    .ACC_W(ACC_W)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .acc_mode (acc_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic             last;
    int unsigned      cyc;
    bit               chk_lat;
  } exp_t;

  exp_t             sb[$];
  logic [SUM_W-1:0] model_acc = '0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [IN_W-1:0] v);
    logic [DW-1:0] d;
    for (int i = 0; i < int'(N_IN); i++) d[i*IN_W +: IN_W] = v;
    return d;
  endfunction

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(N_IN); i++) d[i*IN_W +: IN_W] = IN_W'(i);
    return d;
  endfunction

  function automatic logic [SUM_W-1:0] ref_sum(input logic [DW-1:0] d);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N_IN); i++) s = s + SUM_W'(d[i*IN_W +: IN_W]);
    return s;
  endfunction

  task automatic model_push(input logic [DW-1:0] d, input logic m, input logic l, input bit lat);
    logic [SUM_W-1:0] s;
    s = ref_sum(d);
    if (!m) begin
      sb.push_back('{sum: s, last: l, cyc: cyc, chk_lat: lat});
      model_acc = '0;
    end else if (!l) begin
      model_acc = model_acc + s;
    end else begin
      sb.push_back('{sum: model_acc + s, last: 1'b1, cyc: cyc, chk_lat: lat});
      model_acc = '0;
    end
  endtask

  // Called at a negedge; presents the beat and holds it until accepted.
  task automatic drive(input logic [DW-1:0] d, input logic m, input logic l, input bit lat);
    int unsigned tries = 0;
    in_valid = 1'b1;
    in_data  = d;
    acc_mode = m;
    in_last  = l;
    #1;
    while (!in_ready && tries < 64) begin
      @(negedge Clk);
      #1;
      tries++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else model_push(d, m, l, lat);
    @(negedge Clk);
    in_valid = 1'b0;
    in_data  = '0;
    acc_mode = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge Clk);
  endtask

  // Output monitor: one pop per completed handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (!Reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("out_sum", 64'(out_sum), 64'(e.sum));
          check("out_last", 64'(out_last), 64'(e.last));
          if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(LEVELS + 1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge Clk);

    // Mode 0, single full-scale beat: 16 * 16383 = 262128, latency checked
    drive(fill(14'h3FFF), 1'b0, 1'b1, 1'b1);
    drain();

    // Mode 0, back-to-back: ramp (120) then all ones (16)
    drive(ramp(), 1'b0, 1'b0, 1'b1);
    drive(fill(14'd1), 1'b0, 1'b0, 1'b1);
    drain();

    // Mode 1, three beats of ones -> 48 with out_last
    for (int j = 0; j < 3; j++) drive(fill(14'd1), 1'b1, (j == 2), 1'b0);
    drain();

    // Mode 1, 17 full-scale beats -> 4456176 mod 2^22 = 261872
    for (int j = 0; j < 17; j++) drive(fill(14'h3FFF), 1'b1, (j == 16), 1'b0);
    drain();

    // Mode-0 beat during a partial frame discards the partial sum
    drive(fill(14'd1), 1'b1, 1'b0, 1'b0);
    drive(ramp(), 1'b0, 1'b0, 1'b0);
    drive(fill(14'd1), 1'b1, 1'b1, 1'b0);
    drain();

    // Backpressure: stall three cycles once the first result is presented
    fork
      begin
        for (int j = 1; j <= 6; j++) drive(fill(IN_W'(100 * j)), 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (LEVELS + 1) @(negedge Clk);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_out_sum", 64'(out_sum), 64'(ref_sum(fill(14'd100))));
          @(negedge Clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset during a partial mode-1 frame
    drive(fill(14'd1), 1'b1, 1'b0, 1'b0);
    drive(fill(14'd7), 1'b1, 1'b0, 1'b0);
    repeat (LEVELS + 2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_acc = '0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_acc", 64'(dut.acc_q), 64'd0);
    repeat (LEVELS + 3) @(negedge Clk);
    drive(fill(14'd1), 1'b1, 1'b0, 1'b0);
    drive(fill(14'd1), 1'b1, 1'b1, 1'b0);
    drain();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
